// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store.
// Data side wins ties; a busy-cycle counter aborts stalled transactions.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic [31:0] d_rdata,
   output logic        dmem_valid,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_D,
      BUSY_I
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic             we_q;
   logic             grant_d;
   logic             grant_i;
   logic             done;
   logic             expire;
   logic             busy;
   logic             own_d;
   logic             own_i;

   assign busy  = (state != IDLE);
   assign own_d = (state == BUSY_D);
   assign own_i = (state == BUSY_I);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_d  = 1'b0;
      grant_i  = 1'b0;
      done     = 1'b0;
      expire   = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_req) begin
               state_nx = BUSY_D;
               grant_d  = 1'b1;
            end else if (if_req) begin
               state_nx = BUSY_I;
               grant_i  = 1'b1;
            end
         end
         BUSY_D, BUSY_I: begin
            // an ack in the final allowed cycle still completes normally
            if (mem_ack) begin
               state_nx = IDLE;
               done     = 1'b1;
            end else if (cnt == LAST) begin
               state_nx = IDLE;
               expire   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state_nx == IDLE) begin
         cnt <= '0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
      end else if (grant_d) begin
         addr_q  <= d_addr;
         wdata_q <= d_wdata;
         wstrb_q <= d_we ? d_wstrb : 4'b0000;
         we_q    <= d_we;
      end else if (grant_i) begin
         addr_q  <= if_addr;
         wdata_q <= '0;
         wstrb_q <= 4'b0000;
         we_q    <= 1'b0;
      end
   end

   assign mem_req   = busy;
   assign mem_we    = we_q & own_d;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = own_d ? wstrb_q : 4'b0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_valid   <= 1'b0;
         dmem_valid <= 1'b0;
         err        <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         if_valid   <= own_i & (done | expire);
         dmem_valid <= own_d & (done | expire);
         err        <= expire;
         if (own_i && done) begin
            if_rdata <= mem_rdata;
         end else if (own_i && expire) begin
            if_rdata <= '0;
         end
         // stores return zero so the hold register never shows stale data
         if (own_d && done) begin
            d_rdata <= we_q ? 32'h0 : mem_rdata;
         end else if (own_d && expire) begin
            d_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, hand sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic [31:0] d_rdata;
   logic        dmem_valid;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_vec;
   int n_bad;

   mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .d_rdata   (d_rdata),
      .dmem_valid(dmem_valid),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          lat;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } txn_t;

   txn_t tbl[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input txn_t t);
      logic [3:0] ws;
      ws = (t.is_d && t.we) ? t.wstrb : 4'b0000;
      if (t.is_d) begin
         d_req   = 1'b1;
         d_we    = t.we;
         d_addr  = t.addr;
         d_wdata = t.wdata;
         d_wstrb = t.wstrb;
      end else begin
         if_req  = 1'b1;
         if_addr = t.addr;
      end
      step();
      chk("grant_mem_req", 64'(mem_req), 64'(1));
      for (int k = 0; k < TO; k++) begin
         chk("busy_port", {mem_addr, mem_we, mem_wstrb},
             {t.addr, t.is_d & t.we, ws});
         if (t.is_d && t.we)
            chk("busy_wdata", 64'(mem_wdata), 64'(t.wdata));
         chk("busy_nopulse", {if_valid, dmem_valid, err}, 3'b000);
         chk("busy_req", 64'(mem_req), 64'(1));
         mem_ack   = (k == t.lat);
         mem_rdata = (k == t.lat) ? t.rdata : $urandom;
         step();
         mem_ack = 1'b0;
         if (k == t.lat || k == TO - 1) break;
      end
      chk("done_pulse", {if_valid, dmem_valid, err},
          {!t.is_d, t.is_d, t.exp_err});
      chk("done_rdata", 64'(t.is_d ? d_rdata : if_rdata),
          64'(t.exp_rdata));
      chk("done_req_low", 64'(mem_req), 64'(0));
      d_req  = 1'b0;
      if_req = 1'b0;
      step();
      chk("after_pulse", {if_valid, dmem_valid, err, mem_req}, 4'b0000);
      chk("rdata_hold", 64'(t.is_d ? d_rdata : if_rdata),
          64'(t.exp_rdata));
   endtask

   // reference model state for random traffic
   int          m_own;
   int          m_cnt;
   int          m_lat;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_we;
   logic        e_ifv;
   logic        e_dv;
   logic        e_err;
   logic [31:0] e_if_rdata;
   logic [31:0] e_d_rdata;

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b0;
      if_req = 1'b0;
      if_addr = '0;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = '0;
      d_wdata = '0;
      d_wstrb = '0;
      mem_rdata = '0;
      mem_ack = 1'b0;

      tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0,
                 32'h00000013, 32'h00000013, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 4'b0011, 3,
                 32'h12345678, 32'h0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 32'h2004, 32'h11112222, 4'hF, 1,
                 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 32'h2008, 32'h0, 4'h0, 99,
                 32'h0, 32'h0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 32'h104, 32'h0, 4'h0, TO - 1,
                 32'h00A00093, 32'h00A00093, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 32'h108, 32'h0, 4'h0, 99,
                 32'h0, 32'h0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 32'h40C, 32'h0BADF00D, 4'b1000, 0,
                 32'h77777777, 32'h0, 1'b0};

      step();
      step();
      chk("reset_outs",
          {if_valid, dmem_valid, err, mem_req, mem_we, mem_wstrb},
          9'h0);
      chk("reset_data", {if_rdata, d_rdata}, 64'h0);
      chk("reset_addr", {mem_addr, mem_wdata}, 64'h0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_txn(tbl[i]);

      // tie: data wins, fetch follows once the port frees
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h2000;
      if_req = 1'b1;
      if_addr = 32'h300;
      step();
      chk("tie_first", {mem_req, mem_addr}, {1'b1, 32'h2000});
      mem_ack = 1'b1;
      mem_rdata = 32'hAAAA0000;
      step();
      mem_ack = 1'b0;
      chk("tie_dvalid", {if_valid, dmem_valid, mem_req}, 3'b010);
      chk("tie_drdata", 64'(d_rdata), 64'(32'hAAAA0000));
      d_req = 1'b0;
      step();
      chk("tie_second", {mem_req, mem_we, mem_addr}, {2'b10, 32'h300});
      mem_ack = 1'b1;
      mem_rdata = 32'h00005555;
      step();
      mem_ack = 1'b0;
      chk("tie_ivalid", {if_valid, dmem_valid}, 2'b10);
      chk("tie_irdata", 64'(if_rdata), 64'(32'h00005555));
      if_req = 1'b0;
      step();

      // stray ack while idle
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack = 1'b0;
      chk("stray_ack", {if_valid, dmem_valid, err, mem_req}, 4'b0000);
      step();
      chk("stray_ack2", {if_valid, dmem_valid, err, mem_req}, 4'b0000);
      chk("stray_hold", 64'(d_rdata), 64'(32'hAAAA0000));

      // asynchronous reset during a load
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h3000;
      step();
      chk("rstmid_busy", 64'(mem_req), 64'(1));
      #1 rst = 1'b0;
      #1;
      chk("rstmid_async", {mem_req, dmem_valid, mem_addr},
          {2'b00, 32'h0});
      chk("rstmid_rdata", 64'(d_rdata), 64'(0));
      d_req = 1'b0;
      step();
      rst = 1'b1;
      chk("rstmid_nopulse", {dmem_valid, err, mem_req}, 3'b000);
      step();
      chk("rstmid_idle", {dmem_valid, err, mem_req}, 3'b000);

      // random traffic against the reference model
      rst = 1'b0;
      step();
      rst = 1'b1;
      m_own = 0;
      m_cnt = 0;
      m_lat = 0;
      m_addr = '0;
      m_wdata = '0;
      m_wstrb = '0;
      m_we = 1'b0;
      e_ifv = 1'b0;
      e_dv = 1'b0;
      e_err = 1'b0;
      e_if_rdata = '0;
      e_d_rdata = '0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_pulse", {if_valid, dmem_valid, err},
             {e_ifv, e_dv, e_err});
         chk("rnd_rdata", {if_rdata, d_rdata}, {e_if_rdata, e_d_rdata});
         chk("rnd_req", 64'(mem_req), 64'(m_own != 0));
         if (m_own != 0)
            chk("rnd_port", {mem_addr, mem_we, mem_wstrb},
                {m_addr, m_we, m_wstrb});
         if (m_own == 1 && m_we)
            chk("rnd_wdata", 64'(mem_wdata), 64'(m_wdata));

         if (e_dv) begin
            d_req = 1'b0;
         end else if (!d_req && m_own != 1 && $urandom_range(3) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom);
            d_addr = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
         end else if (d_req && m_own == 1 && $urandom_range(15) == 0) begin
            d_req = 1'b0;
         end
         if (e_ifv) begin
            if_req = 1'b0;
         end else if (!if_req && m_own != 2 && $urandom_range(2) == 0) begin
            if_req = 1'b1;
            if_addr = {$urandom_range(32'h3FFFFFFF), 2'b00};
         end else if (if_req && m_own == 2 && $urandom_range(15) == 0) begin
            if_req = 1'b0;
         end

         mem_rdata = $urandom;
         if (m_own != 0) mem_ack = (m_cnt == m_lat);
         else mem_ack = ($urandom_range(3) == 0);

         e_ifv = 1'b0;
         e_dv = 1'b0;
         e_err = 1'b0;
         if (m_own == 0) begin
            m_cnt = 0;
            m_lat = ($urandom_range(9) == 0) ? 99 : $urandom_range(4);
            if (d_req) begin
               m_own = 1;
               m_addr = d_addr;
               m_we = d_we;
               m_wdata = d_wdata;
               m_wstrb = d_we ? d_wstrb : 4'b0000;
            end else if (if_req) begin
               m_own = 2;
               m_addr = if_addr;
               m_we = 1'b0;
               m_wstrb = 4'b0000;
            end
         end else if (mem_ack || m_cnt == TO - 1) begin
            e_err = !mem_ack;
            if (m_own == 1) begin
               e_dv = 1'b1;
               e_d_rdata = (mem_ack && !m_we) ? mem_rdata : 32'h0;
            end else begin
               e_ifv = 1'b1;
               e_if_rdata = mem_ack ? mem_rdata : 32'h0;
            end
            m_own = 0;
         end else begin
            m_cnt++;
         end
         step();
         mem_ack = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
